// File: rtl/bet_pkg.sv
// Shared types and constants for the betting ledger.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package bet_pkg;

    typedef enum logic [1:0] {
        SIDE_PLAYER = 2'd0,
        SIDE_DEALER = 2'd1,
        SIDE_TIE    = 2'd2,
        SIDE_INV    = 2'd3
    } side_t;

    typedef enum logic [1:0] {
        BET_OPEN = 2'd0,
        LOCKED   = 2'd1,
        SETTLE   = 2'd2,
        BROKE    = 2'd3
    } ledger_state_t;

    typedef enum logic [1:0] {
        OUT_NONE   = 2'd0,
        OUT_PLAYER = 2'd1,
        OUT_DEALER = 2'd2,
        OUT_TIE    = 2'd3
    } outcome_t;

    // Stake multipliers: a winning single-side bet returns stake plus even money,
    // a push returns only the stake.
    localparam int WIN_MULT  = 2;
    localparam int PUSH_MULT = 1;

    // Both lights together mean a tie; no light means the round produced no result.
    function automatic outcome_t decode_outcome(input logic player_win, input logic dealer_win);
        outcome_t o;
        if (player_win && dealer_win) begin
            o = OUT_TIE;
        end else if (player_win) begin
            o = OUT_PLAYER;
        end else if (dealer_win) begin
            o = OUT_DEALER;
        end else begin
            o = OUT_NONE;
        end
        return o;
    endfunction

endpackage

// File: rtl/bet_payout_calc.sv
// Payout for a settled bet: side x outcome x stake -> amount to credit.
// Latency: purely combinational.
// Backpressure: none.
// Ports: side/outcome (2b codes from bet_pkg), stake (BET_W), payout (PAY_W, unsaturated).
module bet_payout_calc
    import bet_pkg::*;
#(
    parameter int BET_W    = 4,
    parameter int PAY_W    = 12,
    parameter int TIE_MULT = 8
) (
    input  logic [1:0]       side,
    input  logic [1:0]       outcome,
    input  logic [BET_W-1:0] stake,
    output logic [PAY_W-1:0] payout
);

    logic [PAY_W-1:0] stake_ext;
    logic [PAY_W-1:0] win_pay;
    logic [PAY_W-1:0] push_pay;
    logic [PAY_W-1:0] tie_pay;

    assign stake_ext = PAY_W'(stake);
    assign win_pay   = stake_ext * PAY_W'(WIN_MULT);
    assign push_pay  = stake_ext * PAY_W'(PUSH_MULT);
    assign tie_pay   = stake_ext * PAY_W'(TIE_MULT + 1);

    always_comb begin
        payout = '0;
        if (outcome == OUT_NONE) begin
            // No result from the table: hand the stake back whatever the side.
            payout = push_pay;
        end else begin
            case (side)
                SIDE_PLAYER: begin
                    if (outcome == OUT_PLAYER)   payout = win_pay;
                    else if (outcome == OUT_TIE) payout = push_pay;
                end
                SIDE_DEALER: begin
                    if (outcome == OUT_DEALER)   payout = win_pay;
                    else if (outcome == OUT_TIE) payout = push_pay;
                end
                SIDE_TIE: begin
                    // Only reachable when tie bets can be accepted at all.
                    if (outcome == OUT_TIE) payout = tie_pay;
                end
                default: payout = '0;
            endcase
        end
    end

endmodule

// File: rtl/bet_ledger.sv
// Player bank: accepts one bet per round, locks it while dealing, settles from the win lights.
// Latency: place_bet -> balance debit 1 edge; round_done -> credit visible 2 edges later.
// Backpressure: none; place_bet is dropped unless betenabled, round_done dropped unless locked.
// Ports: slow_clock, reset (sync, active-high), place_bet/bet_amount/bet_side,
//        round_done/player_win/dealer_win -> betenabled, updatebalanceenable, balance,
//        last_payout, broke.
// Build option: define TIE_BET_EN to make bet_side=2 (tie) a legal bet paid at TIE_MULT:1.
module bet_ledger
    import bet_pkg::*;
#(
    parameter int               BAL_W        = 8,
    parameter int               BET_W        = 4,
    parameter logic [BAL_W-1:0] INIT_BALANCE = BAL_W'(50),
    parameter int               TIE_MULT     = 8
) (
    input  logic             slow_clock,
    input  logic             reset,
    input  logic             place_bet,
    input  logic [BET_W-1:0] bet_amount,
    input  logic [1:0]       bet_side,
    input  logic             round_done,
    input  logic             player_win,
    input  logic             dealer_win,
    output logic             betenabled,
    output logic             updatebalanceenable,
    output logic [BAL_W-1:0] balance,
    output logic [BAL_W-1:0] last_payout,
    output logic             broke
);

    // Four spare bits hold the largest tie payout plus a full balance without wrapping.
    localparam int               PAY_W   = BAL_W + 4;
    localparam logic [PAY_W-1:0] BAL_MAX = PAY_W'({BAL_W{1'b1}});

    ledger_state_t    state;
    logic [BET_W-1:0] stake_q;
    side_t            side_q;
    outcome_t         outcome_q;

    logic             side_ok;
    logic             bet_ok;
    logic [PAY_W-1:0] payout;
    logic [PAY_W-1:0] sum;
    logic [BAL_W-1:0] bal_next;

    always_comb begin
        side_ok = (bet_side == SIDE_PLAYER) || (bet_side == SIDE_DEALER);
`ifdef TIE_BET_EN
        if (bet_side == SIDE_TIE) side_ok = 1'b1;
`endif
    end

    // Stake must be non-zero and covered by the bank, so the debit can never underflow.
    assign bet_ok = side_ok && (bet_amount != '0) && (BAL_W'(bet_amount) <= balance);

    bet_payout_calc #(
        .BET_W    (BET_W),
        .PAY_W    (PAY_W),
        .TIE_MULT (TIE_MULT)
    ) u_payout (
        .side    (side_q),
        .outcome (outcome_q),
        .stake   (stake_q),
        .payout  (payout)
    );

    assign sum      = PAY_W'(balance) + payout;
    assign bal_next = (sum > BAL_MAX) ? {BAL_W{1'b1}} : sum[BAL_W-1:0];

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state               <= BET_OPEN;
            balance             <= INIT_BALANCE;
            last_payout         <= '0;
            stake_q             <= '0;
            side_q              <= SIDE_PLAYER;
            outcome_q           <= OUT_NONE;
            betenabled          <= 1'b1;
            updatebalanceenable <= 1'b0;
            broke               <= 1'b0;
        end else begin
            case (state)
                BET_OPEN: begin
                    // A round_done arriving here is stale and ignored.
                    if (place_bet && bet_ok) begin
                        balance    <= balance - BAL_W'(bet_amount);
                        stake_q    <= bet_amount;
                        side_q     <= side_t'(bet_side);
                        state      <= LOCKED;
                        betenabled <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (round_done) begin
                        outcome_q           <= decode_outcome(player_win, dealer_win);
                        state               <= SETTLE;
                        updatebalanceenable <= 1'b1;
                    end
                end
                SETTLE: begin
                    balance             <= bal_next;
                    last_payout         <= payout[BAL_W-1:0];
                    updatebalanceenable <= 1'b0;
                    if (bal_next == '0) begin
                        state <= BROKE;
                        broke <= 1'b1;
                    end else begin
                        state      <= BET_OPEN;
                        betenabled <= 1'b1;
                    end
                end
                BROKE: begin
                    // Absorbing until reset.
                end
                default: begin
                    state <= BET_OPEN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bet_ledger.sv
// Self-checking bench for bet_ledger: directed rounds plus random traffic against a ledger model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bet_ledger;

    localparam int TIE_MULT = 8;

    logic       slow_clock = 1'b0;
    logic       reset      = 1'b1;
    logic       place_bet  = 1'b0;
    logic [3:0] bet_amount = '0;
    logic [1:0] bet_side   = '0;
    logic       round_done = 1'b0;
    logic       player_win = 1'b0;
    logic       dealer_win = 1'b0;
    logic       betenabled;
    logic       updatebalanceenable;
    logic [7:0] balance;
    logic [7:0] last_payout;
    logic       broke;

    bet_ledger #(.TIE_MULT(TIE_MULT)) dut (
        .slow_clock          (slow_clock),
        .reset               (reset),
        .place_bet           (place_bet),
        .bet_amount          (bet_amount),
        .bet_side            (bet_side),
        .round_done          (round_done),
        .player_win          (player_win),
        .dealer_win          (dealer_win),
        .betenabled          (betenabled),
        .updatebalanceenable (updatebalanceenable),
        .balance             (balance),
        .last_payout         (last_payout),
        .broke               (broke)
    );

    always #5 slow_clock = ~slow_clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Sides: 0 player, 1 dealer, 2 tie. Outcomes: 0 none, 1 player, 2 dealer, 3 tie.
    function automatic int exp_payout(input int side, input int out, input int stake);
        if (out == 0) return stake;
        if (side == 2) return (out == 3) ? (TIE_MULT + 1) * stake : 0;
        if (out == 3) return stake;
        if ((side == 0 && out == 1) || (side == 1 && out == 2)) return 2 * stake;
        return 0;
    endfunction

    function automatic bit side_legal(input int side);
`ifdef TIE_BET_EN
        return side <= 2;
`else
        return side <= 1;
`endif
    endfunction

    bit m_valid  = 0;
    int m_bal    = 0;
    int m_lp     = 0;
    bit m_locked = 0;   // stake held, waiting for the table
    bit m_settle = 0;   // outcome known, credit due on next edge
    bit m_broke  = 0;
    int m_stake  = 0;
    int m_side   = 0;
    int m_out    = 0;

    always @(posedge slow_clock) begin
        if (reset) begin
            m_valid = 1; m_bal = 50; m_lp = 0; m_locked = 0; m_settle = 0;
            m_broke = 0; m_stake = 0; m_side = 0; m_out = 0;
        end else if (m_valid) begin
            if (m_settle) begin
                int p;
                p = exp_payout(m_side, m_out, m_stake);
                m_lp = p % 256;
                m_bal = (m_bal + p > 255) ? 255 : m_bal + p;
                m_settle = 0;
                m_broke = (m_bal == 0);
            end else if (m_broke) begin
                m_broke = 1;
            end else if (m_locked) begin
                if (round_done) begin
                    m_out = (player_win && dealer_win) ? 3 : player_win ? 1 : dealer_win ? 2 : 0;
                    m_locked = 0;
                    m_settle = 1;
                end
            end else if (place_bet && bet_amount != 0 && int'(bet_amount) <= m_bal
                         && side_legal(int'(bet_side))) begin
                m_bal = m_bal - int'(bet_amount);
                m_stake = int'(bet_amount);
                m_side = int'(bet_side);
                m_locked = 1;
            end
        end
    end

    always @(negedge slow_clock) begin
        if (m_valid) begin
            check("betenabled", betenabled, !m_locked && !m_settle && !m_broke);
            check("updatebalanceenable", updatebalanceenable, m_settle);
            check("balance", balance, m_bal);
            check("last_payout", last_payout, m_lp);
            check("broke", broke, m_broke);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic bet(input int a, input int s);
        place_bet = 1'b1;
        bet_amount = a[3:0];
        bet_side = s[1:0];
        tick();
        place_bet = 1'b0;
    endtask

    task automatic finish_round(input bit pw, input bit dw);
        round_done = 1'b1;
        player_win = pw;
        dealer_win = dw;
        tick();
        round_done = 1'b0;
        player_win = 1'b0;
        dealer_win = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        check("pin_tie_pay", exp_payout(2, 3, 10), 90);
        check("pin_push_pay", exp_payout(1, 3, 7), 7);
        check("pin_no_result", exp_payout(0, 0, 4), 4);

        // 1: reset, player bet wins
        tick(); tick();
        reset = 1'b0;
        check("s1_reset_bal", balance, 50);
        check("s1_reset_betenabled", betenabled, 1);
        check("s1_reset_lp", last_payout, 0);
        bet(5, 0);
        check("s1_debit", balance, 45);
        check("s1_locked_betenabled", betenabled, 0);
        round_done = 1'b1; player_win = 1'b1;
        tick();
        round_done = 1'b0; player_win = 1'b0;
        check("s1_settle_pulse", updatebalanceenable, 1);
        tick();
        check("s1_pulse_end", updatebalanceenable, 0);
        check("s1_credit", balance, 55);
        check("s1_last_payout", last_payout, 10);

        // 2: dealer bet, tie -> push
        do_reset();
        bet(7, 1);
        check("s2_debit", balance, 43);
        finish_round(1, 1);
        check("s2_credit", balance, 50);
        check("s2_last_payout", last_payout, 7);

        // 3: tie bet
        do_reset();
        bet(10, 2);
`ifdef TIE_BET_EN
        check("s3_debit", balance, 40);
        finish_round(1, 1);
        check("s3_credit", balance, 130);
        check("s3_last_payout", last_payout, 90);
`else
        check("s3_rejected_bal", balance, 50);
        check("s3_rejected_betenabled", betenabled, 1);
`endif

        // 4: drain to 3, over-bet rejected, go broke
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bet(15, 0);
            finish_round(0, 1);
        end
        bet(2, 0);
        finish_round(0, 1);
        check("s4_bal3", balance, 3);
        bet(5, 0);
        check("s4_overbet_bal", balance, 3);
        check("s4_overbet_betenabled", betenabled, 1);
        bet(3, 0);
        finish_round(0, 1);
        check("s4_zero", balance, 0);
        check("s4_broke", broke, 1);
        bet(1, 0);
        finish_round(1, 0);
        check("s4_absorb_bal", balance, 0);
        check("s4_absorb_broke", broke, 1);
        do_reset();
        check("s4_recover_bal", balance, 50);
        check("s4_recover_broke", broke, 0);

        // 5: climb to 250, saturate, stale round_done
        for (int i = 0; i < 13; i++) begin
            bet(15, 0);
            finish_round(1, 0);
        end
        bet(5, 0);
        finish_round(1, 0);
        check("s5_bal250", balance, 250);
        bet(10, 0);
        finish_round(1, 0);
        check("s5_saturate", balance, 255);
        check("s5_last_payout", last_payout, 20);
        finish_round(1, 0);
        check("s5_stale_round_bal", balance, 255);
        check("s5_stale_round_open", betenabled, 1);

        // same-cycle place_bet + round_done while open: bet taken, round_done dropped
        place_bet = 1'b1; bet_amount = 4'd4; bet_side = 2'd0; round_done = 1'b1; player_win = 1'b1;
        tick();
        place_bet = 1'b0; round_done = 1'b0; player_win = 1'b0;
        check("same_cycle_debit", balance, 251);
        check("same_cycle_locked", betenabled, 0);

        // 6: reset while locked forfeits the stake
        do_reset();
        bet(9, 1);
        check("s6_debit", balance, 41);
        do_reset();
        check("s6_bal", balance, 50);
        check("s6_betenabled", betenabled, 1);
        check("s6_no_pulse", updatebalanceenable, 0);

        // random traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 149) == 0);
            place_bet  = ($urandom_range(0, 2) == 0);
            bet_amount = 4'($urandom_range(0, 15));
            bet_side   = 2'($urandom_range(0, 3));
            round_done = ($urandom_range(0, 3) == 0);
            player_win = 1'($urandom_range(0, 1));
            dealer_win = 1'($urandom_range(0, 1));
            tick();
        end
        reset = 1'b0; place_bet = 1'b0; round_done = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
